// File: rtl/lookup_ram_pipe.sv
// Table RAM with a control port, a two-stage lookup port with hit bits,
// write/invalidate forwarding into the lookup pipe and a clear sweep engine.
module lookup_ram_pipe #(
  parameter int                DATA_W  = 267,
  parameter int                ADDR_W  = 4,
  parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
  input  logic              axis_clk,
  input  logic              axis_rst,
  input  logic              ctrl_wr_en,
  input  logic              ctrl_rd_en,
  input  logic              ctrl_inv_en,
  input  logic              ctrl_clr,
  input  logic [ADDR_W-1:0] ctrl_addr,
  input  logic [DATA_W-1:0] ctrl_din,
  output logic              ctrl_busy,
  output logic              ctrl_rd_valid,
  output logic [DATA_W-1:0] ctrl_dout,
  output logic              ctrl_rd_vld,
  input  logic              lkup_valid,
  input  logic [ADDR_W-1:0] lkup_addr,
  output logic              lkup_out_valid,
  output logic              lkup_hit,
  output logic [DATA_W-1:0] lkup_data
);

  localparam int DEPTH = 2 ** ADDR_W;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_IDLE  = 1'b1;

  localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  r_valid;
  logic [0:0]        r_state;
  logic [ADDR_W-1:0] r_ptr;

  logic              r_s1_vld;
  logic [ADDR_W-1:0] r_s1_addr;
  logic [DATA_W-1:0] r_s1_data;
  logic              r_s1_hit;

  logic              w_idle;
  logic              w_cmd;
  logic              w_inv;
  logic              w_wr;
  logic              w_rd;
  logic [DATA_W-1:0] w_s1_data;
  logic              w_s1_hit;
  logic [DATA_W-1:0] w_s2_data;
  logic              w_s2_hit;

  // clr wins over everything, inv over wr; reads ride along unless clr
  assign w_idle    = (r_state == ST_IDLE);
  assign w_cmd     = w_idle & ~ctrl_clr;
  assign w_inv     = w_cmd & ctrl_inv_en;
  assign w_wr      = w_cmd & ~ctrl_inv_en & ctrl_wr_en;
  assign w_rd      = w_cmd & ctrl_rd_en;
  assign ctrl_busy = ~w_idle;

  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      r_state <= ST_CLEAR;
      r_ptr   <= '0;
      r_valid <= '0;
    end else if (!w_idle) begin
      r_valid[r_ptr] <= 1'b0;
      if (r_ptr == PTR_LAST) begin
        r_state <= ST_IDLE;
      end else begin
        r_ptr <= r_ptr + PTR_ONE;
      end
    end else if (ctrl_clr) begin
      r_state <= ST_CLEAR;
      r_ptr   <= '0;
    end else if (w_inv) begin
      r_valid[ctrl_addr] <= 1'b0;
    end else if (w_wr) begin
      r_valid[ctrl_addr] <= 1'b1;
    end
  end

  always_ff @(posedge axis_clk) begin
    if (!w_idle) begin
      r_mem[r_ptr] <= CLR_VAL;
    end else if (w_wr) begin
      r_mem[ctrl_addr] <= ctrl_din;
    end
  end

  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      ctrl_rd_valid <= 1'b0;
      ctrl_dout     <= '0;
      ctrl_rd_vld   <= 1'b0;
    end else begin
      ctrl_rd_valid <= w_rd;
      if (w_rd) begin
        ctrl_dout   <= r_mem[ctrl_addr];
        ctrl_rd_vld <= r_valid[ctrl_addr];
      end
    end
  end

  // forward the command committing at the same edge that loads each stage
  always_comb begin
    w_s1_data = r_mem[lkup_addr];
    w_s1_hit  = r_valid[lkup_addr];
    if (!w_idle) begin
      w_s1_data = CLR_VAL;
      w_s1_hit  = 1'b0;
    end else if (w_wr && ctrl_addr == lkup_addr) begin
      w_s1_data = ctrl_din;
      w_s1_hit  = 1'b1;
    end else if (w_inv && ctrl_addr == lkup_addr) begin
      w_s1_hit  = 1'b0;
    end
  end

  always_comb begin
    w_s2_data = r_s1_data;
    w_s2_hit  = r_s1_hit;
    if (w_wr && ctrl_addr == r_s1_addr) begin
      w_s2_data = ctrl_din;
      w_s2_hit  = 1'b1;
    end else if (w_inv && ctrl_addr == r_s1_addr) begin
      w_s2_hit  = 1'b0;
    end
  end

  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      r_s1_vld       <= 1'b0;
      r_s1_addr      <= '0;
      r_s1_data      <= '0;
      r_s1_hit       <= 1'b0;
      lkup_out_valid <= 1'b0;
      lkup_hit       <= 1'b0;
      lkup_data      <= '0;
    end else begin
      r_s1_vld       <= lkup_valid;
      r_s1_addr      <= lkup_addr;
      r_s1_data      <= w_s1_data;
      r_s1_hit       <= w_s1_hit;
      lkup_out_valid <= r_s1_vld;
      lkup_hit       <= w_s2_hit;
      lkup_data      <= w_s2_data;
    end
  end

endmodule

// File: tb/tb_lookup_ram_pipe.sv
// Directed bench for lookup_ram_pipe: sweep, readback, forwarding,
// priority, clear command and mid-sweep reset.
module tb_lookup_ram_pipe;

  localparam int DATA_W = 267;
  localparam int ADDR_W = 4;
  localparam logic [DATA_W-1:0] CLRV = 267'h3C3C_0F0F;

  logic              clk;
  logic              rst;
  logic              wr_en;
  logic              rd_en;
  logic              inv_en;
  logic              clr;
  logic [ADDR_W-1:0] caddr;
  logic [DATA_W-1:0] din;
  logic              busy;
  logic              rd_valid;
  logic [DATA_W-1:0] dout;
  logic              rd_vld;
  logic              lv;
  logic [ADDR_W-1:0] laddr;
  logic              ov;
  logic              hit;
  logic [DATA_W-1:0] ldata;

  int total = 0;
  int bad   = 0;

  lookup_ram_pipe #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .CLR_VAL(CLRV)
  ) dut (
    .axis_clk      (clk),
    .axis_rst      (rst),
    .ctrl_wr_en    (wr_en),
    .ctrl_rd_en    (rd_en),
    .ctrl_inv_en   (inv_en),
    .ctrl_clr      (clr),
    .ctrl_addr     (caddr),
    .ctrl_din      (din),
    .ctrl_busy     (busy),
    .ctrl_rd_valid (rd_valid),
    .ctrl_dout     (dout),
    .ctrl_rd_vld   (rd_vld),
    .lkup_valid    (lv),
    .lkup_addr     (laddr),
    .lkup_out_valid(ov),
    .lkup_hit      (hit),
    .lkup_data     (ldata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [DATA_W-1:0] got,
                     input logic [DATA_W-1:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; wr_en = 0; rd_en = 0; inv_en = 0; clr = 0;
    caddr = '0; din = '0; lv = 0; laddr = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1);
    chk("rst_rdv", rd_valid, 0);
    chk("rst_dout", dout, 0);
    chk("rst_rdvld", rd_vld, 0);
    chk("rst_ov", ov, 0);
    chk("rst_hit", hit, 0);
    chk("rst_ldata", ldata, 0);

    // initial sweep with a lookup to addr 3 every cycle
    rst = 1'b0; lv = 1; laddr = 4'd3;
    for (int n = 1; n <= 16; n++) begin
      step();
      chk("sweep_busy", busy, n < 16);
      if (n >= 2) begin
        chk("sweep_ov", ov, 1);
        chk("sweep_hit", hit, 0);
        chk("sweep_data", ldata, CLRV);
      end
    end
    lv = 0;
    step(); step();
    chk("drain_ov", ov, 0);

    // write then read back, then lookup
    wr_en = 1; caddr = 4'd5; din = 'hABCD;
    step();
    wr_en = 0; rd_en = 1;
    step();
    rd_en = 0;
    chk("rb_rdv", rd_valid, 1);
    chk("rb_dout", dout, 'hABCD);
    chk("rb_vld", rd_vld, 1);
    step();
    chk("rb_pulse", rd_valid, 0);
    lv = 1; laddr = 4'd5;
    step();
    lv = 0;
    step();
    chk("lk5_ov", ov, 1);
    chk("lk5_hit", hit, 1);
    chk("lk5_data", ldata, 'hABCD);
    step();
    chk("lk5_once", ov, 0);

    // forwarding into S1 (same cycle) and S2 (next cycle)
    wr_en = 1; caddr = 4'd7; din = 'h77;
    step();
    lv = 1; laddr = 4'd7; din = 'hAA;
    step();
    lv = 0; wr_en = 0;
    step();
    chk("fw0_hit", hit, 1);
    chk("fw0_data", ldata, 'hAA);
    lv = 1;
    step();
    lv = 0; wr_en = 1; din = 'h55;
    step();
    wr_en = 0;
    chk("fw1_ov", ov, 1);
    chk("fw1_hit", hit, 1);
    chk("fw1_data", ldata, 'h55);
    lv = 1;
    step();
    lv = 0;
    step();
    wr_en = 1; din = 'h99;
    chk("fw2_hit", hit, 1);
    chk("fw2_data", ldata, 'h55);
    step();
    wr_en = 0;
    lv = 1;
    step();
    lv = 0;
    step();
    chk("fw3_data", ldata, 'h99);

    // read-before-write, then invalidate with concurrent lookup
    wr_en = 1; rd_en = 1; caddr = 4'd2; din = 'h11;
    step();
    wr_en = 0; rd_en = 0;
    chk("rbw_rdv", rd_valid, 1);
    chk("rbw_dout", dout, CLRV);
    chk("rbw_vld", rd_vld, 0);
    inv_en = 1; lv = 1; laddr = 4'd2;
    step();
    inv_en = 0; lv = 0;
    step();
    chk("inv_ov", ov, 1);
    chk("inv_hit", hit, 0);
    chk("inv_data", ldata, 'h11);
    rd_en = 1;
    step();
    rd_en = 0;
    chk("inv_dout", dout, 'h11);
    chk("inv_vld", rd_vld, 0);

    // inv beats wr in the same cycle
    inv_en = 1; wr_en = 1; caddr = 4'd5; din = 'h1234;
    step();
    inv_en = 0; wr_en = 0; rd_en = 1;
    step();
    rd_en = 0;
    chk("pri_dout", dout, 'hABCD);
    chk("pri_vld", rd_vld, 0);

    // clear command with a write alongside, and commands during busy
    clr = 1; wr_en = 1; caddr = 4'd4; din = 'h44;
    step();
    clr = 0; wr_en = 0;
    chk("clr_busy", busy, 1);
    chk("clr_nord", rd_valid, 0);
    for (int i = 1; i <= 16; i++) begin
      if (i <= 3) begin
        wr_en = 1; rd_en = 1; caddr = 4'd6; din = 'h66;
      end else begin
        wr_en = 0; rd_en = 0;
      end
      step();
      chk("clr_sweep_busy", busy, i < 16);
      chk("clr_sweep_rdv", rd_valid, 0);
    end
    lv = 1; laddr = 4'd4;
    step();
    laddr = 4'd6;
    step();
    lv = 0;
    chk("clr4_hit", hit, 0);
    chk("clr4_data", ldata, CLRV);
    step();
    chk("clr6_hit", hit, 0);
    chk("clr6_data", ldata, CLRV);
    rd_en = 1; caddr = 4'd5;
    step();
    rd_en = 0;
    chk("clr5_dout", dout, CLRV);
    chk("clr5_vld", rd_vld, 0);

    // reset at sweep ptr 9 with lookups in flight
    clr = 1;
    step();
    clr = 0;
    repeat (7) step();
    lv = 1; laddr = 4'd1;
    step(); step();
    chk("pre_rst_ov", ov, 1);
    rst = 1; lv = 0;
    #1;
    chk("mid_rst_ov", ov, 0);
    chk("mid_rst_busy", busy, 1);
    chk("mid_rst_hit", hit, 0);
    step(); step();
    rst = 0;
    for (int i = 1; i <= 16; i++) begin
      step();
      chk("rst_sweep_busy", busy, i < 16);
      chk("rst_sweep_ov", ov, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lookup_ram_pipe.md
# lookup_ram_pipe

Parametrised single-clock table RAM for the packet-processing path. A control port does table updates and readback; a lookup port does fixed-latency reads with per-entry valid (hit) bits. Same-cycle write-to-lookup forwarding is built in, and a sweeping clear engine runs after reset or on command. It replaces fixed-size table RAMs in the match/action stages: tables are generalised in width and depth and can be cleared without reprogramming from software.

## Interface
Parameters:
- DATA_W, 267, entry width in bits
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W entries
- CLR_VAL, 0, DATA_W-bit value written to every entry by the clear sweep

Ports:
- axis_clk  in  1  sole clock; all logic rising-edge
- axis_rst  in  1  asynchronous, active-high reset
- ctrl_wr_en  in  1  write entry ctrl_addr with ctrl_din; sets its valid bit
- ctrl_rd_en  in  1  read entry ctrl_addr
- ctrl_inv_en  in  1  clear valid bit of ctrl_addr; data untouched
- ctrl_clr  in  1  start full-table clear sweep
- ctrl_addr  in  ADDR_W  control address
- ctrl_din  in  DATA_W  write data
- ctrl_busy  out  1  clear sweep in progress; control commands dropped
- ctrl_rd_valid  out  1  one-cycle pulse, ctrl_dout/ctrl_rd_vld valid
- ctrl_dout  out  DATA_W  readback data
- ctrl_rd_vld  out  1  valid bit of the read entry
- lkup_valid  in  1  lookup request
- lkup_addr  in  ADDR_W  lookup address
- lkup_out_valid  out  1  lookup result valid
- lkup_hit  out  1  entry valid bit
- lkup_data  out  DATA_W  entry data

## Operation
- FSM states: CLEAR, IDLE. axis_rst forces CLEAR with sweep pointer 0.
- CLEAR:
  - Each cycle, write CLR_VAL to mem[ptr] and clear valid[ptr]; ptr++.
  - After ptr = DEPTH-1 is written, go to IDLE.
  - Sweep takes exactly DEPTH cycles.
  - ctrl_busy = 1 throughout.
- IDLE:
  - ctrl_busy = 0.
  - ctrl_clr = 1 goes to CLEAR next cycle with ptr = 0. Any other control command in that same cycle is dropped.
- Control commands in CLEAR are dropped silently: no write, no ctrl_rd_valid.
- Priority within one IDLE cycle: clr > inv > wr. A read is always serviced alongside inv or wr.
  - Readback is read-before-write: ctrl_dout returns the data present before the same-cycle write.
- Valid bits are a DEPTH-bit register vector, async-reset to 0. Memory data is not reset; it is initialised only by the sweep.
- Lookup pipeline, two stages, no backpressure. Every accepted lkup_valid yields exactly one lkup_out_valid.
  - S1: register address, mem data and valid bit.
  - S2: output registers.
- Forwarding: a lookup issued in cycle T reflects every control write or invalidate committed in cycles ≤ T+1 to the same address, i.e. including the cycle it sits in S1.
  - Write forwards ctrl_din with hit = 1.
  - Invalidate forwards hit = 0 with data unchanged.
- Lookups during CLEAR are accepted and return hit = 0, lkup_data = CLR_VAL regardless of sweep progress.

## Timing
- Reset values:
  - All outputs 0, except ctrl_busy = 1 (state CLEAR).
  - Pipeline valids 0; ptr 0.
- After axis_rst deasserts: ctrl_busy falls after DEPTH rising edges, e.g. 16 for ADDR_W = 4.
- Control write/invalidate: effective at the edge that samples it. A read in cycle T+1 sees the new value.
- Control read: ctrl_rd_valid, ctrl_dout and ctrl_rd_vld are asserted in cycle T+1 for 1 cycle.
- Lookup: request in cycle T gives lkup_out_valid in cycle T+2. Full throughput, one lookup per cycle.
- Reset mid-sweep or mid-lookup:
  - In-flight lookups are discarded; no lkup_out_valid after reset.
  - Sweep restarts from 0.
- Address wrap: none. ptr stops at DEPTH-1; addresses are always in range by width.

## Test plan
- Reset, then lkup_valid to addr 3 every cycle -> ctrl_busy = 1 for 16 cycles; each result hit = 0, data = CLR_VAL; then busy = 0.
- IDLE, write addr 5 = 0xABCD, read addr 5 next cycle -> ctrl_rd_valid at T+2 with dout = 0xABCD, ctrl_rd_vld = 1. Lookup addr 5 -> hit = 1, data = 0xABCD at +2.
- Lookup addr 7 in cycle T; write addr 7 = 0x55 in T+1 -> result at T+2: hit = 1, data = 0x55. Write instead in T+2 -> old value returned.
- Write addr 2 = 0x11; same-cycle read addr 2 -> dout = old value. Then inv addr 2 with concurrent lookup addr 2 -> hit = 0, data = 0x11.
- Issue ctrl_clr together with ctrl_wr_en to addr 4 -> write dropped. Any write during busy dropped. After 16 cycles, lookup addr 4 -> hit = 0, data = CLR_VAL.
- Assert axis_rst at sweep ptr = 9 with lookups in flight -> outputs 0, busy = 1; no stale lkup_out_valid; full 16-cycle sweep follows.
